sdram_req_arbiter: RTL and testbench

- Shares the single toggle-handshake SDRAM port between two requesters: the Oric CPU RAM bus and the FDC disk-image buffer.
- Runs in the 72 MHz SDRAM clock domain.
- Replaces ad-hoc edge detection of the CPU strobes with a proper scheduler: fixed CPU priority, a pending slot per requester, byte-lane steering and read-data capture.

---
 rtl/sdram_req_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Two-requester scheduler (Oric CPU, FDC image buffer) for a toggle-handshake SDRAM port.
// Optional macro SDRAM_ARB_FAIR_EN forces an FDC grant after FAIR_LIMIT CPU grants.
module sdram_req_arbiter #(
  parameter int                 SD_AW      = 24,
  parameter int                 FDC_AW     = 20,
  parameter logic [SD_AW-1:0]   CPU_BASE   = 24'h000000,
  parameter logic [SD_AW-1:0]   FDC_BASE   = 24'h100000,
  parameter int                 FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_a,
  input  logic [7:0]        cpu_d,
  output logic [7:0]        cpu_q,
  output logic              cpu_busy,
  input  logic              fdc_req,
  input  logic              fdc_we,
  input  logic [FDC_AW-1:0] fdc_a,
  input  logic [7:0]        fdc_d,
  output logic [7:0]        fdc_q,
  output logic              fdc_ack,
  output logic              fdc_busy,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [SD_AW-1:0]  sd_a,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q
);

  if (FDC_AW > SD_AW || SD_AW < 16) begin : g_bad_width
    $error("sdram_req_arbiter: address widths out of range");
  end
  if (FAIR_LIMIT < 1 || FAIR_LIMIT > 7) begin : g_bad_fair
    $error("sdram_req_arbiter: FAIR_LIMIT must fit the 3-bit grant counter");
  end

  typedef enum logic [1:0] {IDLE, CPU_WAIT, FDC_WAIT} state_t;

  state_t state, state_n;
  logic   grant_cpu, grant_fdc, done;
  logic   fair_force;

  logic        cpu_pend, fdc_pend;
  logic [15:0] cpu_a_r;
  logic [7:0]  cpu_d_r;
  logic        cpu_we_r;
  logic [FDC_AW-1:0] fdc_a_r;
  logic [7:0]  fdc_d_r;
  logic        fdc_we_r;
  logic        hi_sel;

  logic        rd, wr, prev_rd, prev_wr;
  logic [15:0] prev_a;
  logic        cpu_detect;
  logic [7:0]  rd_byte;

  assign rd = cpu_cs & cpu_oe;
  assign wr = cpu_cs & cpu_we;
  assign cpu_detect = (rd & ~prev_rd) | (wr & ~prev_wr) | (rd & prev_rd & (cpu_a != prev_a));

  assign cpu_busy = cpu_pend | (state == CPU_WAIT);
  assign fdc_busy = fdc_pend | (state == FDC_WAIT);
  assign rd_byte  = hi_sel ? sd_q[15:8] : sd_q[7:0];

  function automatic logic [1:0] lane_ds(input logic we, input logic a0);
    if (!we)    return 2'b11;
    else if (a0) return 2'b10;
    else        return 2'b01;
  endfunction

`ifdef SDRAM_ARB_FAIR_EN
  logic [2:0] fair_cnt;

  assign fair_force = (fair_cnt >= 3'(FAIR_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      fair_cnt <= '0;
    end else if (grant_fdc) begin
      fair_cnt <= '0;
    end else if (grant_cpu && fdc_pend && fair_cnt != 3'd7) begin
      fair_cnt <= fair_cnt + 3'd1;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    grant_cpu = 1'b0;
    grant_fdc = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fdc_pend && (!cpu_pend || fair_force)) begin
          grant_fdc = 1'b1;
          state_n   = FDC_WAIT;
        end else if (cpu_pend) begin
          grant_cpu = 1'b1;
          state_n   = CPU_WAIT;
        end
      end
      CPU_WAIT, FDC_WAIT: begin
        if (sd_ack == sd_req) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Preloading the strobe history with the live inputs keeps reset release from looking like an edge.
      prev_rd  <= rd;
      prev_wr  <= wr;
      prev_a   <= cpu_a;
      cpu_pend <= 1'b0;
      fdc_pend <= 1'b0;
      cpu_a_r  <= '0;
      cpu_d_r  <= '0;
      cpu_we_r <= 1'b0;
      fdc_a_r  <= '0;
      fdc_d_r  <= '0;
      fdc_we_r <= 1'b0;
      hi_sel   <= 1'b0;
      cpu_q    <= '0;
      fdc_q    <= '0;
      fdc_ack  <= 1'b0;
      sd_req   <= 1'b0;
      sd_a     <= '0;
      sd_ds    <= '0;
      sd_we    <= 1'b0;
      sd_d     <= '0;
    end else begin
      prev_rd <= rd;
      prev_wr <= wr;
      prev_a  <= cpu_a;
      fdc_ack <= 1'b0;

      // A detect in the grant cycle wins over the clear, so it stays queued.
      if (grant_cpu) cpu_pend <= 1'b0;
      if (cpu_detect) begin
        cpu_pend <= 1'b1;
        cpu_a_r  <= cpu_a;
        cpu_d_r  <= cpu_d;
        cpu_we_r <= wr;
      end

      if (grant_fdc) fdc_pend <= 1'b0;
      if (fdc_req && !fdc_busy) begin
        fdc_pend <= 1'b1;
        fdc_a_r  <= fdc_a;
        fdc_d_r  <= fdc_d;
        fdc_we_r <= fdc_we;
      end

      if (grant_cpu) begin
        sd_req <= ~sd_req;
        sd_a   <= CPU_BASE + SD_AW'(cpu_a_r[15:1]);
        sd_ds  <= lane_ds(cpu_we_r, cpu_a_r[0]);
        sd_we  <= cpu_we_r;
        sd_d   <= {cpu_d_r, cpu_d_r};
        hi_sel <= cpu_a_r[0];
      end else if (grant_fdc) begin
        sd_req <= ~sd_req;
        sd_a   <= FDC_BASE + SD_AW'(fdc_a_r[FDC_AW-1:1]);
        sd_ds  <= lane_ds(fdc_we_r, fdc_a_r[0]);
        sd_we  <= fdc_we_r;
        sd_d   <= {fdc_d_r, fdc_d_r};
        hi_sel <= fdc_a_r[0];
      end

      if (done) begin
        if (state == CPU_WAIT) begin
          if (!sd_we) cpu_q <= rd_byte;
        end else begin
          if (!sd_we) fdc_q <= rd_byte;
          fdc_ack <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: stimulus queues expected SDRAM commands and FDC
// read bytes; a monitor pops and compares them as the DUT toggles sd_req / pulses fdc_ack.
module tb_sdram_req_arbiter;

  localparam logic [23:0] FDC_BASE = 24'h100000;

  typedef struct {
    logic [23:0] a;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_oe, cpu_we;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        cpu_busy;
  logic        fdc_req, fdc_we;
  logic [19:0] fdc_a;
  logic [7:0]  fdc_d;
  logic [7:0]  fdc_q;
  logic        fdc_ack, fdc_busy;
  logic        sd_req, sd_ack;
  logic [23:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d, sd_q;

  int total = 0;
  int bad   = 0;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_fdcq[$];

  int          ack_delay = 5;
  logic [15:0] rsp_q = '0;
  int          cmd_cnt = 0;
  int          fdc_ack_cnt = 0;
  bit          check_cmds = 1'b1;
  bit          streaming = 1'b0;
  int          cpu_since = 0;
  int          fdc_at = -1;
  bit          fdc_during_stream = 1'b0;

  sdram_req_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_cs   (cpu_cs),
    .cpu_oe   (cpu_oe),
    .cpu_we   (cpu_we),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .cpu_q    (cpu_q),
    .cpu_busy (cpu_busy),
    .fdc_req  (fdc_req),
    .fdc_we   (fdc_we),
    .fdc_a    (fdc_a),
    .fdc_d    (fdc_d),
    .fdc_q    (fdc_q),
    .fdc_ack  (fdc_ack),
    .fdc_busy (fdc_busy),
    .sd_req   (sd_req),
    .sd_ack   (sd_ack),
    .sd_a     (sd_a),
    .sd_ds    (sd_ds),
    .sd_we    (sd_we),
    .sd_d     (sd_d),
    .sd_q     (sd_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for both sides to go idle; gap = cycles from first ack match to idle.
  task automatic wait_done(input string name, output int gap);
    int  m = -1;
    bit  mis = 1'b0;
    int  k;
    gap = -1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cpu_busy && !fdc_busy) break;
      if (sd_req !== sd_ack) mis = 1'b1;
      else if (mis && m < 0) m = k;
    end
    if (k == 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still busy after 300 cycles", name);
    end else if (m >= 0) begin
      gap = k - m;
    end
  endtask

  function automatic cmd_t mk(input logic [23:0] a, input logic [1:0] ds, input logic we,
                              input logic [15:0] d);
    cmd_t c;
    c.a = a; c.ds = ds; c.we = we; c.d = d;
    return c;
  endfunction

  // SDRAM model: acks ack_delay cycles after seeing a new toggle, reset from the same source.
  initial begin
    int wcnt = 0;
    sd_ack = 1'b0;
    sd_q   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        sd_ack = 1'b0;
        wcnt   = 0;
      end else if (sd_req !== sd_ack) begin
        if (wcnt >= ack_delay - 1) begin
          sd_q   = rsp_q;
          sd_ack = sd_req;
          wcnt   = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: compares each issued command and each fdc_ack against the scoreboard.
  initial begin
    logic prev_req = 1'b0;
    cmd_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (sd_req !== prev_req) begin
          prev_req = sd_req;
          cmd_cnt++;
          if (!check_cmds) begin
            if (sd_a >= FDC_BASE) begin
              if (fdc_at < 0) begin
                fdc_at = cpu_since;
                fdc_during_stream = streaming;
              end
            end else begin
              cpu_since++;
            end
          end else if (exp_cmd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_cmd: got sd_a=%0h with nothing expected", sd_a);
          end else begin
            e = exp_cmd.pop_front();
            check("cmd_sd_a", sd_a, e.a);
            check("cmd_sd_ds", sd_ds, e.ds);
            check("cmd_sd_we", sd_we, e.we);
            if (e.we) check("cmd_sd_d", sd_d, e.d);
          end
        end
        if (fdc_ack) begin
          fdc_ack_cnt++;
          if (exp_fdcq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_fdc_ack: fdc_q=%0h with nothing expected", fdc_q);
          end else begin
            check("fdc_q", fdc_q, exp_fdcq.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && fdc_req) assert (!fdc_busy) else $error("fdc_req issued while fdc_busy");
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   gap;
    int   c0, a0;
    logic req0;

    reset  = 1'b1;
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0;
    cpu_a  = 16'h1234; cpu_d = 8'h00;
    fdc_req = 1'b0; fdc_we = 1'b0; fdc_a = '0; fdc_d = '0;
    tick(3);

    // Reset state
    check("rst_sd_req", sd_req, 0);
    check("rst_sd_a", sd_a, 0);
    check("rst_cpu_q", cpu_q, 0);
    check("rst_busy", {cpu_busy, fdc_busy, fdc_ack}, 0);

    // Strobes already active at reset release must not create a request
    reset = 1'b0;
    tick(4);
    check("no_req_after_reset", cpu_busy, 0);
    check("no_cmd_after_reset", cmd_cnt, 0);
    cpu_oe = 1'b0;
    tick(2);

    // CPU read, odd address -> high byte
    rsp_q = 16'hAB12;
    cpu_a = 16'h1235;
    exp_cmd.push_back(mk(24'h00091A, 2'b11, 1'b0, 16'h0));
    req0 = sd_req;
    cpu_oe = 1'b1;
    tick(1);
    check("busy_after_detect", cpu_busy, 1);
    check("sd_req_not_yet", sd_req, req0);
    tick(1);
    check("sd_req_toggled", sd_req, !req0);
    cpu_oe = 1'b0;
    wait_done("cpu_read", gap);
    check("read_ack_to_idle", gap, 1);
    check("cpu_q_read", cpu_q, 8'hAB);
    check("read_cmd_count", cmd_cnt, 1);

    // CPU write, even address -> low lane
    cpu_a = 16'h0400; cpu_d = 8'h5C;
    exp_cmd.push_back(mk(24'h000200, 2'b01, 1'b1, 16'h5C5C));
    cpu_we = 1'b1;
    tick(1);
    cpu_we = 1'b0;
    wait_done("cpu_write", gap);
    check("write_ack_to_idle", gap, 1);
    check("cpu_q_kept_after_write", cpu_q, 8'hAB);

    // CPU write, odd address -> high lane
    cpu_a = 16'h0401; cpu_d = 8'h77;
    exp_cmd.push_back(mk(24'h000200, 2'b10, 1'b1, 16'h7777));
    cpu_we = 1'b1;
    tick(1);
    cpu_we = 1'b0;
    wait_done("cpu_write_odd", gap);

    // CPU read at top of the 64 KB region
    rsp_q = 16'hC3D4;
    cpu_a = 16'hFFFF;
    exp_cmd.push_back(mk(24'h007FFF, 2'b11, 1'b0, 16'h0));
    cpu_oe = 1'b1;
    tick(1);
    cpu_oe = 1'b0;
    wait_done("cpu_read_top", gap);
    check("cpu_q_top", cpu_q, 8'hC3);

    // Collision: CPU served first, then FDC (even address -> low byte)
    rsp_q = 16'h3C96;
    cpu_a = 16'h8003;
    fdc_a = 20'h000A4; fdc_we = 1'b0;
    exp_cmd.push_back(mk(24'h004001, 2'b11, 1'b0, 16'h0));
    exp_cmd.push_back(mk(24'h100052, 2'b11, 1'b0, 16'h0));
    exp_fdcq.push_back(8'h96);
    a0 = fdc_ack_cnt;
    cpu_oe = 1'b1; fdc_req = 1'b1;
    tick(1);
    fdc_req = 1'b0; cpu_oe = 1'b0;
    check("fdc_busy_pending", fdc_busy, 1);
    wait_done("collision", gap);
    check("collision_cpu_q", cpu_q, 8'h3C);
    check("collision_fdc_acks", fdc_ack_cnt, a0 + 1);

    // FDC write at top of its address space; fdc_q stays unchanged
    fdc_a = 20'hFFFFF; fdc_we = 1'b1; fdc_d = 8'hE1;
    exp_cmd.push_back(mk(24'h17FFFF, 2'b10, 1'b1, 16'hE1E1));
    exp_fdcq.push_back(8'h96);
    a0 = fdc_ack_cnt;
    fdc_req = 1'b1;
    tick(1);
    fdc_req = 1'b0; fdc_we = 1'b0;
    wait_done("fdc_write", gap);
    check("fdc_write_acks", fdc_ack_cnt, a0 + 1);

    // Address streaming with oe held: one command per distinct address
    ack_delay = 2;
    rsp_q = 16'h5A69;
    exp_cmd.push_back(mk(24'h000000, 2'b11, 1'b0, 16'h0));
    exp_cmd.push_back(mk(24'h000000, 2'b11, 1'b0, 16'h0));
    exp_cmd.push_back(mk(24'h000001, 2'b11, 1'b0, 16'h0));
    c0 = cmd_cnt;
    cpu_a = 16'h0000; cpu_oe = 1'b1;
    tick(10);
    cpu_a = 16'h0001;
    tick(10);
    cpu_a = 16'h0002;
    tick(10);
    cpu_oe = 1'b0;
    wait_done("stream", gap);
    check("stream_cmd_count", cmd_cnt - c0, 3);
    check("stream_cpu_q", cpu_q, 8'h69);

    // Reset while the FDC command is in flight
    ack_delay = 1000;
    fdc_a = 20'h00010; fdc_we = 1'b0;
    exp_cmd.push_back(mk(24'h100008, 2'b11, 1'b0, 16'h0));
    fdc_req = 1'b1;
    tick(1);
    fdc_req = 1'b0;
    tick(3);
    check("fdc_in_flight", {fdc_busy, sd_req ^ sd_ack}, 2'b11);
    c0 = cmd_cnt;
    a0 = fdc_ack_cnt;
    reset = 1'b1;
    tick(1);
    check("midrst_sd_req", sd_req, 0);
    check("midrst_busy", {cpu_busy, fdc_busy, fdc_ack}, 0);
    check("midrst_sd_a", sd_a, 0);
    check("midrst_q", {cpu_q, fdc_q}, 0);
    reset = 1'b0;
    ack_delay = 5;
    tick(10);
    check("midrst_no_stale_cmd", cmd_cnt, c0);
    check("midrst_no_fdc_ack", fdc_ack_cnt, a0);

    // CPU re-requests every cycle while the FDC is pending
    ack_delay = 1;
    rsp_q = 16'h1122;
    fdc_a = 20'h00020; fdc_we = 1'b0;
    exp_fdcq.push_back(8'h22);
    check_cmds = 1'b0;
    cpu_since = 0;
    fdc_at = -1;
    streaming = 1'b1;
    cpu_a = 16'h0100;
    cpu_oe = 1'b1; fdc_req = 1'b1;
    tick(1);
    fdc_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cpu_a = cpu_a + 16'd1;
      tick(1);
    end
    streaming = 1'b0;
    cpu_oe = 1'b0;
    wait_done("fair", gap);
    check_cmds = 1'b1;
`ifdef SDRAM_ARB_FAIR_EN
    check("fair_cpu_grants_before_fdc", fdc_at, 4);
`else
    check("fdc_waits_for_cpu_stop", fdc_during_stream, 0);
    check("many_cpu_grants_before_fdc", fdc_at >= 10, 1);
`endif

    tick(3);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("fdcq_queue_drained", exp_fdcq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
